// File: rtl/mem_req_master.sv
// Single-outstanding request master for the 32x8 handshake memory: holds a
// level request until ack, retries on timeout, and returns one response per command.
module mem_req_master #(
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 8,
   parameter int TIMEOUT   = 16,
   parameter int MAX_RETRY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int ATT_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
   localparam logic [ATT_W-1:0]   ATT_LAST   = ATT_W'(MAX_RETRY);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t              state_r,     state_s;
   logic                op_write_r,  op_write_s;
   logic [TIMER_W-1:0]  timer_r,     timer_s;
   logic [ATT_W-1:0]    attempt_r,   attempt_s;
   logic                mem_read_r,  mem_read_s;
   logic                mem_write_r, mem_write_s;
   logic [ADDR_W-1:0]   mem_addr_r,  mem_addr_s;
   logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_s;
   logic                rsp_valid_r, rsp_valid_s;
   logic [DATA_W-1:0]   rsp_rdata_r, rsp_rdata_s;
   logic                rsp_err_r,   rsp_err_s;

   assign cmd_ready = (state_r == IDLE);
   assign mem_read  = mem_read_r;
   assign mem_write = mem_write_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;
   assign rsp_err   = rsp_err_r;

   // Next-state and next-output logic; every output is computed here and registered below.
   always_comb begin
      state_s     = state_r;
      op_write_s  = op_write_r;
      timer_s     = timer_r;
      attempt_s   = attempt_r;
      mem_read_s  = mem_read_r;
      mem_write_s = mem_write_r;
      mem_addr_s  = mem_addr_r;
      mem_wdata_s = mem_wdata_r;
      rsp_valid_s = rsp_valid_r;
      rsp_rdata_s = rsp_rdata_r;
      rsp_err_s   = rsp_err_r;

      case (state_r)
         IDLE: begin
            if (cmd_valid) begin
               op_write_s  = cmd_write;
               mem_addr_s  = cmd_addr;
               mem_wdata_s = cmd_wdata;
               attempt_s   = {ATT_W{1'b0}};
               timer_s     = {TIMER_W{1'b0}};
               mem_read_s  = !cmd_write;
               mem_write_s = cmd_write;
               state_s     = REQ;
            end else begin
               state_s = IDLE;
            end
         end
         REQ: begin
            // ack wins over a timeout landing in the same cycle
            if (mem_ack) begin
               mem_read_s  = 1'b0;
               mem_write_s = 1'b0;
               rsp_rdata_s = op_write_r ? {DATA_W{1'b0}} : mem_rdata;
               rsp_err_s   = 1'b0;
               rsp_valid_s = 1'b1;
               state_s     = RESP;
            end else if (timer_r == TIMER_LAST) begin
               mem_read_s  = 1'b0;
               mem_write_s = 1'b0;
               if (attempt_r < ATT_LAST) begin
                  attempt_s = attempt_r + ATT_W'(1);
                  state_s   = GAP;
               end else begin
                  rsp_rdata_s = {DATA_W{1'b0}};
                  rsp_err_s   = 1'b1;
                  rsp_valid_s = 1'b1;
                  state_s     = RESP;
               end
            end else begin
               timer_s = timer_r + TIMER_W'(1);
            end
         end
         GAP: begin
            timer_s     = {TIMER_W{1'b0}};
            mem_read_s  = !op_write_r;
            mem_write_s = op_write_r;
            state_s     = REQ;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_s = 1'b0;
               state_s     = IDLE;
            end else begin
               rsp_valid_s = 1'b1;
            end
         end
         default: begin
            mem_read_s  = 1'b0;
            mem_write_s = 1'b0;
            rsp_valid_s = 1'b0;
            state_s     = IDLE;
         end
      endcase
   end

   // State and registered outputs; async reset drops any active request at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         op_write_r  <= 1'b0;
         timer_r     <= {TIMER_W{1'b0}};
         attempt_r   <= {ATT_W{1'b0}};
         mem_read_r  <= 1'b0;
         mem_write_r <= 1'b0;
         mem_addr_r  <= {ADDR_W{1'b0}};
         mem_wdata_r <= {DATA_W{1'b0}};
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= {DATA_W{1'b0}};
         rsp_err_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         op_write_r  <= op_write_s;
         timer_r     <= timer_s;
         attempt_r   <= attempt_s;
         mem_read_r  <= mem_read_s;
         mem_write_r <= mem_write_s;
         mem_addr_r  <= mem_addr_s;
         mem_wdata_r <= mem_wdata_s;
         rsp_valid_r <= rsp_valid_s;
         rsp_rdata_r <= rsp_rdata_s;
         rsp_err_r   <= rsp_err_s;
      end
   end

endmodule

// File: tb/tb_mem_req_master.sv
// Bench for mem_req_master: behavioural 32x8 handshake memory with selectable
// ack behaviour, a directed vector table, and hand-written timeout/reset sequences.
module tb_mem_req_master;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_write = 1'b0;
   logic [4:0] cmd_addr = 5'd0;
   logic [7:0] cmd_wdata = 8'd0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       mem_read;
   logic       mem_write;
   logic [4:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_ack;
   logic [7:0] mem_rdata;

   int checks = 0;
   int errors = 0;
   int rises  = 0;
   int hi_cyc = 0;
   int mode   = 0;   // 0 = random latency 1..10, 1 = never ack, 2 = ack on 16th request cycle
   logic stray_ack = 1'b0;

   mem_req_master #(.ADDR_W(5), .DATA_W(8), .TIMEOUT(16), .MAX_RETRY(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: counts request cycles, pulses ack, then waits for the request to drop.
   logic       m_ack, m_wait;
   logic [7:0] m_rdata;
   logic [7:0] mem [32];
   int         m_cnt, m_lat;
   logic       req_m;
   assign req_m     = mem_read | mem_write;
   assign mem_ack   = m_ack | stray_ack;
   assign mem_rdata = m_ack ? m_rdata : 8'hEE;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ack <= 1'b0; m_rdata <= 8'h00; m_cnt <= 0; m_wait <= 1'b0; m_lat <= 3;
      end else begin
         m_ack <= 1'b0;
         m_rdata <= 8'h00;
         if (m_wait) begin
            m_cnt <= 0;
            if (!req_m) m_wait <= 1'b0;
         end else if (req_m) begin
            if (mode != 1 && m_cnt + 1 == ((mode == 2) ? 15 : m_lat)) begin
               m_ack  <= 1'b1;
               m_wait <= 1'b1;
               m_cnt  <= 0;
               m_lat  <= int'($urandom_range(1, 10));
               if (mem_write) mem[mem_addr] <= mem_wdata;
               else           m_rdata <= (mode == 2) ? 8'h3C : mem[mem_addr];
            end else begin
               m_cnt <= m_cnt + 1;
            end
         end else begin
            m_cnt <= 0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Per-cycle protocol monitor: exclusivity, stability while held, request pulse/cycle counts.
   initial begin
      logic       p_req = 1'b0;
      logic       p_rd = 1'b0;
      logic [4:0] p_addr = 5'd0;
      logic [7:0] p_wd = 8'd0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("req_exclusive", 32'(mem_read & mem_write), 32'd0);
            if (req_m && p_req)
               check("req_stable", 32'({mem_read, mem_addr, mem_wdata}), 32'({p_rd, p_addr, p_wd}));
            if (req_m && !p_req) rises++;
            if (req_m) hi_cyc++;
         end
         p_req = req_m; p_rd = mem_read; p_addr = mem_addr; p_wd = mem_wdata;
      end
   end

   task automatic send(input logic wr, input logic [4:0] a, input logic [7:0] wd, input string tag);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
      check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      check({tag, " req_next_cycle"}, 32'({mem_read, mem_write}), 32'({!wr, wr}));
   endtask

   task automatic wait_rsp(output int cyc);
      cyc = 0;
      @(negedge clk);
      while (!rsp_valid && cyc < 200) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic finish_rsp(input string tag);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check({tag, " rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
      check({tag, " cmd_ready_back"}, 32'(cmd_ready), 32'd1);
   endtask

   task automatic do_cmd(input logic wr, input logic [4:0] a, input logic [7:0] wd,
                         input logic [7:0] exp_rd, input logic exp_err, input string tag);
      int c, r0;
      r0 = rises;
      send(wr, a, wd, tag);
      wait_rsp(c);
      check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, " rsp_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
      check({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
      check({tag, " single_req"}, 32'(rises - r0), 32'd1);
      finish_rsp(tag);
   endtask

   typedef struct {
      logic       wr;
      logic [4:0] a;
      logic [7:0] wd;
      logic [7:0] exp_rd;
      logic       exp_err;
   } vec_t;

   vec_t tbl[8];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, r0, h0;
      tbl[0] = '{1'b1, 5'h05, 8'hA5, 8'h00, 1'b0};
      tbl[1] = '{1'b0, 5'h05, 8'h00, 8'hA5, 1'b0};
      tbl[2] = '{1'b1, 5'h1F, 8'h5A, 8'h00, 1'b0};
      tbl[3] = '{1'b0, 5'h1F, 8'h11, 8'h5A, 1'b0};
      tbl[4] = '{1'b1, 5'h00, 8'hFF, 8'h00, 1'b0};
      tbl[5] = '{1'b0, 5'h00, 8'h00, 8'hFF, 1'b0};
      tbl[6] = '{1'b1, 5'h05, 8'h00, 8'h00, 1'b0};
      tbl[7] = '{1'b0, 5'h05, 8'h00, 8'h00, 1'b0};

      repeat (3) @(negedge clk);
      check("reset_outputs", 32'({mem_read, mem_write, mem_addr, mem_wdata, rsp_valid, rsp_rdata, rsp_err}), 32'd0);
      check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++)
         do_cmd(tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].exp_rd, tbl[i].exp_err, $sformatf("vec%0d", i));

      for (int i = 0; i < 32; i++)
         do_cmd(1'b1, 5'(i), 8'(i) ^ 8'h3C, 8'h00, 1'b0, $sformatf("fill_wr%0d", i));
      for (int i = 0; i < 32; i++)
         do_cmd(1'b0, 5'(i), 8'h00, 8'(i) ^ 8'h3C, 1'b0, $sformatf("fill_rd%0d", i));

      // Response back-pressure: everything frozen while rsp_ready is low.
      send(1'b0, 5'h0A, 8'h00, "hold");
      wait_rsp(c);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'h01; cmd_wdata = 8'h77;
      for (int i = 0; i < 20; i++) begin
         check("hold state", 32'({rsp_valid, rsp_rdata, rsp_err, cmd_ready, mem_read}), 32'({1'b1, 8'h36, 1'b0, 1'b0, 1'b0}));
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      finish_rsp("hold");

      // Stray ack while idle must be ignored.
      @(negedge clk);
      stray_ack = 1'b1;
      @(negedge clk);
      stray_ack = 1'b0;
      check("stray_ack", 32'({rsp_valid, cmd_ready, mem_read, mem_write}), 32'({1'b0, 1'b1, 1'b0, 1'b0}));

      // Ack on the last permitted cycle of the first attempt.
      mode = 2;
      r0 = rises; h0 = hi_cyc;
      send(1'b0, 5'h07, 8'h00, "late_ack");
      wait_rsp(c);
      check("late_ack latency", 32'(c), 32'd16);
      check("late_ack rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'({1'b1, 1'b0, 8'h3C}));
      check("late_ack pulses", 32'(rises - r0), 32'd1);
      check("late_ack hi_cycles", 32'(hi_cyc - h0), 32'd16);
      finish_rsp("late_ack");
      mode = 0;

      // Memory never acks: three 16-cycle attempts with 1-cycle gaps, then error.
      mode = 1;
      r0 = rises; h0 = hi_cyc;
      send(1'b0, 5'h03, 8'h00, "timeout");
      wait_rsp(c);
      check("timeout latency", 32'(c), 32'd50);
      check("timeout rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'({1'b1, 1'b1, 8'h00}));
      check("timeout pulses", 32'(rises - r0), 32'd3);
      check("timeout hi_cycles", 32'(hi_cyc - h0), 32'd48);
      finish_rsp("timeout");

      // Reset in the middle of a held request.
      send(1'b0, 5'h04, 8'h00, "rst_mid");
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid async_drop", 32'({mem_read, mem_write, rsp_valid}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mode = 0;
      @(negedge clk);
      check("rst_mid after", 32'({cmd_ready, mem_read, rsp_valid}), 32'({1'b1, 1'b0, 1'b0}));
      do_cmd(1'b0, 5'h12, 8'h00, 8'h2E, 1'b0, "post_rst");

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
